// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU and its arbiter/sequencer.
//   alu_op_t    - 2-bit ALU operation encoding (AND/ADD/XOR/SUB)
//   arb_state_t - sequencer states (IDLE -> EXEC -> RESP -> IDLE)
//   ALU_WIDTH   - datapath width of the shared ALU
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    // Settle counter width; covers EXEC_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_ADD = 2'b01,
        ALU_XOR = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin winner select.
//   req        - request vector, bit i from requester i
//   last_grant - index of the requester that won most recently
//   grant      - one-hot winner (all zero when req is zero)
// On a tie the requester that did not win last time gets the grant,
// which guarantees a waiting requester is served next.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the main datapath (requester 0) and
// the branch/loop-address unit (requester 1).
//   CLK, Reset            - clock, asynchronous active-high reset
//   Req[1:0]              - per-requester request, sampled only in IDLE
//   Op0/A0/B0, Op1/A1/B1  - operation and operands per requester
//   Grant[1:0]            - one-cycle pulse: request accepted, operands latched
//   Done[1:0]             - one-cycle pulse: ResultOut/ZeroOut valid
//   ResultOut, ZeroOut    - captured ALU outputs, held until the next capture
//   Busy                  - high whenever not IDLE
//   ALUOp/ALUSrcA/ALUSrcB - registered drive to the ALU
//   ALUResult, ALUZero    - ALU outputs
// One operation in flight at a time: accept in IDLE, hold the ALU inputs for
// EXEC_CYCLES cycles (legal 1..15), capture, pulse Done during RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH       = ALU_WIDTH,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       Req,
    input  logic [1:0]       Op0,
    input  logic [1:0]       Op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] B1,
    output logic [1:0]       Grant,
    output logic [1:0]       Done,
    output logic [WIDTH-1:0] ResultOut,
    output logic             ZeroOut,
    output logic             Busy,
    output logic [1:0]       ALUOp,
    output logic [WIDTH-1:0] ALUSrcA,
    output logic [WIDTH-1:0] ALUSrcB,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             ALUZero
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    // Index of the most recent winner; also identifies the owner of the
    // operation in flight, so it doubles as the Done steering bit.
    logic             last_grant;
    logic [1:0]       win;

    rr_arbiter2 u_rr (
        .req        (Req),
        .last_grant (last_grant),
        .grant      (win)
    );

    assign Busy = (state != IDLE);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;   // requester 0 wins the first tie
            Grant      <= 2'b00;
            Done       <= 2'b00;
            ResultOut  <= '0;
            ZeroOut    <= 1'b0;
            ALUOp      <= ALU_AND;
            ALUSrcA    <= '0;
            ALUSrcB    <= '0;
        end else begin
            // Grant and Done are single-cycle pulses by default.
            Grant <= 2'b00;
            Done  <= 2'b00;
            case (state)
                IDLE: begin
                    if (Req != 2'b00) begin
                        if (win[1]) begin
                            ALUOp   <= Op1;
                            ALUSrcA <= A1;
                            ALUSrcB <= B1;
                        end else begin
                            ALUOp   <= Op0;
                            ALUSrcA <= A0;
                            ALUSrcB <= B0;
                        end
                        Grant      <= win;
                        last_grant <= win[1];
                        cnt        <= CNT_LOAD;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        ResultOut <= ALUResult;
                        ZeroOut   <= ALUZero;
                        Done      <= last_grant ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
